// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point helpers for the neuron layer stages.
// Optional macro NEURON_OUT_ROUND_EN: when defined, requant rounds half up
// (toward +inf) before the shift; otherwise it truncates (floor).
package nn_pkg;

  function automatic int res_w(input int qm, input int qn);
    return qm + qn;
  endfunction

  function automatic int out_w(input int om, input int on);
    return om + on;
  endfunction

  // Q(qm.qn) -> Q(om.on) on a 64-bit sign-extended value. The caller keeps the
  // low om+on bits; clamping to the output range is the saturation step.
  function automatic logic signed [63:0] requant(input logic signed [63:0] x,
                                                 input int qn,
                                                 input int om,
                                                 input int on);
    logic signed [63:0] acc;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    int sh;
    int ob;
    sh  = qn - on;
    ob  = om + on;
    acc = x;
`ifdef NEURON_OUT_ROUND_EN
    if (sh > 0) acc = acc + (64'sd1 <<< (sh - 1));
`endif
    acc = acc >>> sh;
    hi  = (64'sd1 <<< (ob - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (ob - 1));
    if (acc > hi)      acc = hi;
    else if (acc < lo) acc = lo;
    return acc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, async active-low reset
// and synchronous clear. The head word reads as zero while empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/neuron_out_collector.sv
// neuron_out_collector: captures neuron results on their done pulse,
// requantises Q(QM.QN) -> Q(OM.ON) with saturation, buffers them in a FIFO
// and streams them out with a frame-end marker every M results.
// Optional macro NEURON_OUT_ROUND_EN selects round-half-up requantisation.
module neuron_out_collector
  import nn_pkg::*;
#(
  parameter int QM    = 12,
  parameter int QN    = 20,
  parameter int OM    = 4,
  parameter int ON    = 4,
  parameter int DEPTH = 8,
  parameter int M     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [QM+QN-1:0]     in_data,
  input  logic                        in_done,
  input  logic                        clear,
  output logic signed [OM+ON-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow
);

  localparam int RW = res_w(QM, QN);
  localparam int OB = out_w(OM, ON);
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic signed [63:0]   ext_p0;
  logic signed [OB-1:0] rq_p0;
  logic signed [OB-1:0] data_p1;
  logic                 vld_p1;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [OB-1:0]        fifo_dout;
  logic [CW-1:0]        frame_cnt;
  logic                 ovf_q;

  assign ext_p0 = {{(64-RW){in_data[RW-1]}}, in_data};
  assign rq_p0  = OB'(requant(ext_p0, QN, OM, ON));

  // Stage p0 -> p1: capture the requantised result on the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= in_done && !clear;
  end

  // Stage p1 data register; qualified by vld_p1, so left unreset.
  always_ff @(posedge clk) begin
    if (in_done) data_p1 <= rq_p0;
  end

  // Stage p1 -> FIFO: push unless full without a pop freeing a slot.
  assign pop  = out_valid && out_ready;
  assign push = vld_p1 && (!full || pop);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OB)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (data_p1),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = fifo_dout;

  // Sticky overflow: a captured result found the FIFO full with no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_q <= 1'b0;
    else if (clear)                  ovf_q <= 1'b0;
    else if (vld_p1 && full && !pop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;

  // Frame position of the head entry; advances on every pop, wraps at M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     frame_cnt <= '0;
    else if (clear) frame_cnt <= '0;
    else if (pop) begin
      if (frame_cnt == CW'(M - 1)) frame_cnt <= '0;
      else                         frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign out_last = out_valid && (frame_cnt == CW'(M - 1));

endmodule

// File: tb/tb_neuron_out_collector.sv
// tb_neuron_out_collector: table-driven, directed and randomised checks of
// neuron_out_collector against a queue-based reference model.
module tb_neuron_out_collector;

  localparam int QM = 12, QN = 20, OM = 4, ON = 4, DEPTH = 8, M = 4;
  localparam int RW = QM + QN;
  localparam int OB = OM + ON;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_done = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic [OB-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          overflow;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [OB-1:0] mq[$];
  logic          pend_v = 1'b0;
  logic [OB-1:0] pend_d = '0;
  logic          m_ovf = 1'b0;
  int            m_pops = 0;

  typedef struct {
    logic [RW-1:0] din;
    logic [OB-1:0] dout;
    string         name;
  } vec_t;

  vec_t          tbl[12];
  logic [RW-1:0] vals[9];

  always #5 clk = ~clk;

  neuron_out_collector #(
    .QM(QM), .QN(QN), .OM(OM), .ON(ON), .DEPTH(DEPTH), .M(M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_done   (in_done),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow)
  );

  // Real-valued requantisation: floor(x / 2^(QN-ON)) (optionally +half), clamped.
  function automatic logic [OB-1:0] ref_q(input logic [RW-1:0] d);
    longint v, den, r, fl, hi, lo;
    v   = longint'(signed'(d));
    den = longint'(1) << (QN - ON);
`ifdef NEURON_OUT_ROUND_EN
    if (QN > ON) v = v + den / 2;
`endif
    r = v % den;
    if (r < 0) r = r + den;
    fl = (v - r) / den;
    hi = (longint'(1) << (OB - 1)) - 1;
    lo = -(longint'(1) << (OB - 1));
    if (fl > hi) fl = hi;
    if (fl < lo) fl = lo;
    return fl[OB-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_v = 1'b0;
    m_ovf  = 1'b0;
    m_pops = 0;
  endtask

  task automatic cmp_model(input string tag);
    logic ev;
    ev = (mq.size() > 0);
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".level"}, 32'(level), 32'(mq.size()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".last"}, 32'(out_last), 32'(ev && ((m_pops % M) == M - 1)));
    if (ev) check({tag, ".data"}, 32'(out_data), 32'(mq[0]));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cycle(input logic d, input logic [RW-1:0] x, input logic r,
                       input logic c, input string tag);
    in_done = d; in_data = x; out_ready = r; clear = c;
    @(posedge clk);
    if (!rst_n || c) begin
      model_reset();
    end else begin
      if (r && mq.size() > 0) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_d);
        else                   m_ovf = 1'b1;
      end
    end
    pend_v = rst_n && !c && d;
    pend_d = ref_q(x);
    #1;
    cmp_model(tag);
  endtask

  task automatic idle(input int n, input logic r, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, r, 1'b0, tag);
  endtask

  initial begin
    tbl[0]  = '{32'h0018_0000, 8'h18, "t_1p5"};
    tbl[1]  = '{32'h0640_0000, 8'h7F, "t_sat_pos"};
    tbl[2]  = '{32'hF9C0_0000, 8'h80, "t_sat_neg"};
    tbl[3]  = '{32'h0000_0000, 8'h00, "t_zero"};
`ifdef NEURON_OUT_ROUND_EN
    tbl[4]  = '{32'h0000_8000, 8'h01, "t_half_lsb"};
    tbl[5]  = '{32'hFFFF_8000, 8'h00, "t_neg_half_lsb"};
`else
    tbl[4]  = '{32'h0000_8000, 8'h00, "t_half_lsb"};
    tbl[5]  = '{32'hFFFF_8000, 8'hFF, "t_neg_half_lsb"};
`endif
    tbl[6]  = '{32'h0000_7FFF, 8'h00, "t_below_half"};
    tbl[7]  = '{32'hFFE8_0000, 8'hE8, "t_m1p5"};
    tbl[8]  = '{32'h007F_0000, 8'h7F, "t_max_exact"};
    tbl[9]  = '{32'h0080_0000, 8'h7F, "t_sat_edge_pos"};
    tbl[10] = '{32'hFF80_0000, 8'h80, "t_min_exact"};
    tbl[11] = '{32'hFF7F_0000, 8'h80, "t_sat_edge_neg"};

    // reset state
    model_reset();
    idle(2, 1'b0, "reset");
    check("reset.out_data", 32'(out_data), 32'h0);
    check("reset.out_last", 32'(out_last), 32'h0);
    rst_n = 1'b1;
    idle(1, 1'b0, "post_reset");

    // table of single results: 2-edge latency, value, pop
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].din, 1'b0, 1'b0, "tbl_cap");
      check({tbl[i].name, ".no_bypass"}, 32'(out_valid), 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b0, "tbl_push");
      check({tbl[i].name, ".data"}, 32'(out_data), 32'(tbl[i].dout));
      check({tbl[i].name, ".level1"}, 32'(level), 32'h1);
      cycle(1'b0, '0, 1'b1, 1'b0, "tbl_pop");
      check({tbl[i].name, ".level0"}, 32'(level), 32'h0);
    end

    // full / overflow with frame marking on the drain
    cycle(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    for (int i = 0; i < 9; i++) begin
      vals[i] = 32'($signed(24'($urandom)));
      cycle(1'b1, vals[i], 1'b0, 1'b0, "ovf_fill");
    end
    idle(1, 1'b0, "ovf_settle");
    check("ovf.level", 32'(level), 32'(DEPTH));
    check("ovf.flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("ovf.order", 32'(out_data), 32'(ref_q(vals[i])));
      check("ovf.last", 32'(out_last), 32'((i == 3) || (i == 7)));
      cycle(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
    end
    check("ovf.empty", 32'(out_valid), 32'h0);

    // simultaneous push and pop at full
    cycle(1'b0, '0, 1'b0, 1'b1, "sim_clr");
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, "sim_fill");
    idle(1, 1'b0, "sim_settle");
    cycle(1'b1, 32'h0010_0000, 1'b0, 1'b0, "sim_cap");
    cycle(1'b0, '0, 1'b1, 1'b0, "sim_pp");
    check("sim.level", 32'(level), 32'(DEPTH));
    check("sim.overflow", 32'(overflow), 32'h0);
    idle(9, 1'b1, "sim_drain");

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [RW-1:0] x;
      x = 32'($urandom);
      if ($urandom_range(0, 1) == 1) x = 32'($signed(x[23:0]));
      cycle($urandom_range(0, 99) < 60, x, $urandom_range(0, 99) < 40,
            $urandom_range(0, 199) == 0, "rnd");
    end

    // clear mid-stream with coincident in_done
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_pre");
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, "clr_fill");
    idle(1, 1'b0, "clr_settle");
    cycle(1'b0, '0, 1'b1, 1'b0, "clr_pop");
    cycle(1'b1, 32'h0018_0000, 1'b0, 1'b1, "clr_hit");
    check("clr.level", 32'(level), 32'h0);
    check("clr.valid", 32'(out_valid), 32'h0);
    check("clr.overflow", 32'(overflow), 32'h0);
    check("clr.out_data", 32'(out_data), 32'h0);
    idle(2, 1'b0, "clr_idle");
    check("clr.dropped_done", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, "clr_refill");
    idle(1, 1'b0, "clr_settle2");
    for (int i = 0; i < 4; i++) begin
      check("clr.frame_last", 32'(out_last), 32'(i == 3));
      cycle(1'b0, '0, 1'b1, 1'b0, "clr_drain");
    end

    // asynchronous reset mid-cycle
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, "rst_fill");
    idle(1, 1'b0, "rst_settle");
    cycle(1'b0, '0, 1'b1, 1'b0, "rst_pop");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.level", 32'(level), 32'h0);
    check("arst.valid", 32'(out_valid), 32'h0);
    check("arst.overflow", 32'(overflow), 32'h0);
    check("arst.out_data", 32'(out_data), 32'h0);
    check("arst.last", 32'(out_last), 32'h0);
    cycle(1'b1, 32'h0018_0000, 1'b0, 1'b0, "arst_hold");
    rst_n = 1'b1;
    idle(2, 1'b0, "arst_idle");
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, "arst_refill");
    idle(1, 1'b0, "arst_settle");
    for (int i = 0; i < 4; i++) begin
      check("arst.frame_last", 32'(out_last), 32'(i == 3));
      cycle(1'b0, '0, 1'b1, 1'b0, "arst_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_out_collector.md
Name: neuron_out_collector

Overview:
- Downstream stage of the serial/semi-serial neuron: captures each neuron result on its one-cycle done pulse.
- Requantises the result from Q(QM.QN) to the OB-bit layer format Q(OM.ON), with saturation.
- Buffers results in a FIFO and presents them to the next layer or host on a valid/ready stream.
- Marks the last result of each M-result frame (one frame = one layer output vector).

Parameters:
- QM, 12, integer bits of neuron result (incl. sign)
- QN, 20, fraction bits of neuron result
- OM, 4, integer bits of output word (incl. sign); OM <= QM
- ON, 4, fraction bits of output word; ON <= QN, OM+ON = OB of neuron layer
- DEPTH, 8, FIFO entries; power of two, >= 2
- M, 4, results per frame (out_last period); >= 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  QM+QN  neuron result, two's complement Q(QM.QN)
- in_done  in  1  one-cycle pulse; in_data valid this cycle
- clear  in  1  synchronous flush (FIFO, stage, frame counter, overflow)
- out_data  out  OM+ON  requantised result, two's complement Q(OM.ON)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_last  out  1  out_data is the M-th result of its frame
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n low): stage empty; FIFO empty; level=0; out_valid=0; out_data=0; out_last=0; overflow=0; frame counter=0.
- Deassertion of reset is synchronised by the system; the block makes no assumption about rst_n relative to in_done. Reset mid-stream discards all contents.
- Stage 1 (capture):
  - Edge where in_done=1 registers requant(in_data) into stage reg and sets stage_valid. Otherwise stage_valid clears.
  - Back-to-back in_done pulses are each captured.
- Requant:
  - Sign-extend to QM+QN+1 bits, then arithmetic shift right by QN-ON.
  - If the upper bits above OM+ON-1 are not all equal to the sign, saturate to +max (0111..) or -min (1000..) according to sign.
- Stage 2 (push), at the edge after capture:
  - If stage_valid and (not full or pop this edge), write to FIFO.
  - If stage_valid and full with no pop, drop the entry and set overflow=1 (held until clear or reset).
- Pop: the edge where out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Simultaneous push and pop: level unchanged; allowed when full and when level=1.
- No bypass: an entry becomes visible one edge after it is pushed.
- Latency: in_done high at edge E0 -> out_valid high after E1 if FIFO was empty (2 edges).
- out_data/out_valid come directly from the FIFO head register/flags, with no combinational path from out_ready.
- Pointers wrap modulo DEPTH. full = level==DEPTH, empty = level==0.
- Frame counter:
  - Increments on each pop and wraps M-1 -> 0.
  - out_last = out_valid and counter==M-1. For M=1, out_last = out_valid.
- clear:
  - Takes priority over push/pop on the same edge; all state returns to reset values.
  - An in_done coincident with clear is discarded.

Optional Feature:
- Macro: NEURON_OUT_ROUND_EN
- Defined: requant adds 1<<(QN-ON-1) before the shift (round half up toward +inf), then saturates. The add is skipped when QN==ON.
- Not defined: plain truncation (floor) by the arithmetic shift.
- Saturation is identical in both cases.

Decomposition:
- Shared package nn_pkg holds:
  - localparam functions for result width (QM+QN) and out width (OM+ON)
  - the requant function (shift, round, saturate), reused by other layer stages
- One sub-module: sync_fifo (DEPTH, WIDTH; push, pop, data in/out, level, full, empty; async active-low reset, sync clear). The collector instantiates it with WIDTH=OM+ON.

Test Plan:
- Basic: in_data=0x0018_0000 (1.5) with in_done, out_ready=1 -> out_valid rises 2 edges later, out_data=0x18, level 1 -> 0 after pop.
- Saturation: in_data=100.0 (0x0640_0000) -> out_data=0x7F. in_data=-100.0 -> 0x80. in_data=0 -> 0x00.
- Rounding: in_data=0x0000_8000 (1/32) -> 0x01 with NEURON_OUT_ROUND_EN, 0x00 without. in_data=0x0000_7FFF -> 0x00 in both.
- Full/overflow: out_ready=0, 9 back-to-back done pulses with DEPTH=8 -> level=8, overflow=1. First 8 values are popped in order; the 9th is absent.
- Frame marking: M=4, 8 results, then out_ready toggled randomly -> out_last only on the 4th and 8th pops. Simultaneous push+pop at level=8 keeps level=8 with overflow=0.
- Clear/reset mid-stream: 3 entries queued, then clear with a coincident in_done -> level=0, out_valid=0, overflow=0, frame counter restarts. Repeating this with rst_n asserted mid-cycle gives the same result immediately.
